// File: rtl/debounce_pkg.sv
// Shared types and lockout constants for the push-button debouncer.
package debounce_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    LOCK_PRESS   = 2'd1,
    HELD         = 2'd2,
    LOCK_RELEASE = 2'd3
  } debounce_state_t;

  // Lockout lengths at a 50 MHz clock.
  localparam int unsigned DEBOUNCE_CYCLES_100MS = 5_000_000;
  localparam int unsigned DEBOUNCE_CYCLES_20MS  = 1_000_000;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchronizer, lockout FSM and counter,
// registered press/release pulses and a held level decoded from state.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_100MS
) (
  input  logic clock,
  input  logic reset,
  input  logic button_n,
  output logic pressed,
  output logic released,
  output logic held
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] TERMINAL = CW'(DEBOUNCE_CYCLES - 1);

  logic            sync1, sync2;
  debounce_state_t state, state_next;
  logic [CW-1:0]   count, count_next;
  logic            pressed_next, released_next;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= button_n;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= RELEASED;
      count    <= '0;
      pressed  <= 1'b0;
      released <= 1'b0;
    end else begin
      state    <= state_next;
      count    <= count_next;
      pressed  <= pressed_next;
      released <= released_next;
    end
  end

  // The counter only advances inside a lockout and is cleared on every exit,
  // so it can never run past TERMINAL.
  always_comb begin
    state_next    = state;
    count_next    = count;
    pressed_next  = 1'b0;
    released_next = 1'b0;
    case (state)
      RELEASED: begin
        if (!sync2) begin
          state_next   = LOCK_PRESS;
          count_next   = '0;
          pressed_next = 1'b1;
        end
      end
      LOCK_PRESS: begin
        if (count == TERMINAL) begin
          state_next = HELD;
          count_next = '0;
        end else begin
          count_next = count + CW'(1);
        end
      end
      HELD: begin
        if (sync2) begin
          state_next    = LOCK_RELEASE;
          count_next    = '0;
          released_next = 1'b1;
        end
      end
      LOCK_RELEASE: begin
        if (count == TERMINAL) begin
          state_next = RELEASED;
          count_next = '0;
        end else begin
          count_next = count + CW'(1);
        end
      end
      default: begin
        state_next = RELEASED;
        count_next = '0;
      end
    endcase
  end

  assign held = (state == LOCK_PRESS) || (state == HELD);

endmodule

// File: rtl/button_debouncer.sv
// Array of independent debounced button channels for active-low push buttons.
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned BUTTON_COUNT    = 3,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_100MS
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [BUTTON_COUNT-1:0] button_n,
  output logic [BUTTON_COUNT-1:0] button_pressed,
  output logic [BUTTON_COUNT-1:0] button_released,
  output logic [BUTTON_COUNT-1:0] button_held
);

  for (genvar i = 0; i < int'(BUTTON_COUNT); i++) begin : g_channel
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_channel (
      .clock    (clock),
      .reset    (reset),
      .button_n (button_n[i]),
      .pressed  (button_pressed[i]),
      .released (button_released[i]),
      .held     (button_held[i])
    );
  end

endmodule
